// File: rtl/rs_pkg.sv
// Shared reservation-station types and op_func encodings ({funct7, funct3, opcode}),
// used by the ALU reservation station and the ALU itself.
package rs_pkg;

    localparam int OPRAND_WIDTH  = 32;
    localparam int OP_FUNC_WIDTH = 17;
    localparam int TAG_WIDTH     = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [OP_FUNC_WIDTH-1:0] ADD  = {7'b0000000, 3'b000, OPC_OP};
    localparam logic [OP_FUNC_WIDTH-1:0] SUB  = {7'b0100000, 3'b000, OPC_OP};
    localparam logic [OP_FUNC_WIDTH-1:0] SLL  = {7'b0000000, 3'b001, OPC_OP};
    localparam logic [OP_FUNC_WIDTH-1:0] SLT  = {7'b0000000, 3'b010, OPC_OP};
    localparam logic [OP_FUNC_WIDTH-1:0] SLTU = {7'b0000000, 3'b011, OPC_OP};
    localparam logic [OP_FUNC_WIDTH-1:0] XOR  = {7'b0000000, 3'b100, OPC_OP};
    localparam logic [OP_FUNC_WIDTH-1:0] SRL  = {7'b0000000, 3'b101, OPC_OP};
    localparam logic [OP_FUNC_WIDTH-1:0] SRA  = {7'b0100000, 3'b101, OPC_OP};
    localparam logic [OP_FUNC_WIDTH-1:0] OR   = {7'b0000000, 3'b110, OPC_OP};
    localparam logic [OP_FUNC_WIDTH-1:0] AND  = {7'b0000000, 3'b111, OPC_OP};
    localparam logic [OP_FUNC_WIDTH-1:0] ADDI = {7'b0000000, 3'b000, OPC_OP_IMM};
    localparam logic [OP_FUNC_WIDTH-1:0] SLTI = {7'b0000000, 3'b010, OPC_OP_IMM};
    localparam logic [OP_FUNC_WIDTH-1:0] XORI = {7'b0000000, 3'b100, OPC_OP_IMM};
    localparam logic [OP_FUNC_WIDTH-1:0] ORI  = {7'b0000000, 3'b110, OPC_OP_IMM};
    localparam logic [OP_FUNC_WIDTH-1:0] ANDI = {7'b0000000, 3'b111, OPC_OP_IMM};
    localparam logic [OP_FUNC_WIDTH-1:0] BEQ  = {7'b0000000, 3'b000, OPC_BRANCH};
    localparam logic [OP_FUNC_WIDTH-1:0] BNE  = {7'b0000000, 3'b001, OPC_BRANCH};
    localparam logic [OP_FUNC_WIDTH-1:0] BLT  = {7'b0000000, 3'b100, OPC_BRANCH};
    localparam logic [OP_FUNC_WIDTH-1:0] LUI  = {7'b0000000, 3'b000, OPC_LUI};
    localparam logic [OP_FUNC_WIDTH-1:0] JAL  = {7'b0000000, 3'b000, OPC_JAL};
    localparam logic [OP_FUNC_WIDTH-1:0] JALR = {7'b0000000, 3'b000, OPC_JALR};

    typedef struct packed {
        logic                    rdy;
        logic [OPRAND_WIDTH-1:0] val;
        logic [TAG_WIDTH-1:0]    tag;
    } rs_src_t;

    // Default-configuration view of one station entry.
    typedef struct packed {
        logic                     valid;
        logic [OP_FUNC_WIDTH-1:0] op_func;
        logic [TAG_WIDTH-1:0]     rob_tag;
        rs_src_t                  src1;
        rs_src_t                  src2;
    } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Picks the oldest ready entry using an age matrix (age[i][j] = entry i older than j).
module rs_oldest_select
    import rs_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    output logic [DEPTH-1:0]            grant,
    output logic                        any_ready
);

    // An entry wins when no other ready entry is older than it.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                grant[i] = grant[i] & ~(ready[j] & age[j][i] & (i != j));
            end
        end
        any_ready = |ready;
    end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: dispatch, CDB wakeup, oldest-first issue
// with a locked, registered issue port.
module alu_rs
    import rs_pkg::*;
#(
    parameter int OPRAND_WIDTH  = 32,
    parameter int OP_FUNC_WIDTH = 17,
    parameter int TAG_WIDTH     = rs_pkg::TAG_WIDTH,
    parameter int DEPTH         = 4
)(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       disp_valid_i,
    output logic                       disp_ready_o,
    input  logic [OP_FUNC_WIDTH-1:0]   disp_op_func_i,
    input  logic [TAG_WIDTH-1:0]       disp_rob_tag_i,
    input  logic                       disp_src1_rdy_i,
    input  logic                       disp_src2_rdy_i,
    input  logic [OPRAND_WIDTH-1:0]    disp_src1_val_i,
    input  logic [OPRAND_WIDTH-1:0]    disp_src2_val_i,
    input  logic [TAG_WIDTH-1:0]       disp_src1_tag_i,
    input  logic [TAG_WIDTH-1:0]       disp_src2_tag_i,
    input  logic                       cdb_valid_i,
    input  logic [TAG_WIDTH-1:0]       cdb_tag_i,
    input  logic [OPRAND_WIDTH-1:0]    cdb_value_i,
    output logic                       iss_valid_o,
    input  logic                       iss_ready_i,
    output logic [OPRAND_WIDTH-1:0]    iss_oprand1_o,
    output logic [OPRAND_WIDTH-1:0]    iss_oprand2_o,
    output logic [OP_FUNC_WIDTH-1:0]   iss_op_func_o,
    output logic [TAG_WIDTH-1:0]       iss_rob_tag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                    rdy;
        logic [OPRAND_WIDTH-1:0] val;
        logic [TAG_WIDTH-1:0]    tag;
    } src_t;

    typedef struct packed {
        logic                     valid;
        logic [OP_FUNC_WIDTH-1:0] op_func;
        logic [TAG_WIDTH-1:0]     rob_tag;
        src_t                     src1;
        src_t                     src2;
    } entry_t;

    entry_t                      entry_r [DEPTH];
    entry_t                      entry_s [DEPTH];
    entry_t                      disp_entry_s;
    logic [DEPTH-1:0][DEPTH-1:0] age_r, age_s;
    logic [CW-1:0]               count_r, count_s;
    logic                        disp_ready_r, disp_ready_s;
    logic [DEPTH-1:0]            valid_vec_s, free_onehot_s, ready_vec_s, grant_s;
    logic                        any_ready_s, disp_fire_s, iss_fire_s;

    logic                        iss_valid_r, iss_valid_s;
    logic [DEPTH-1:0]            iss_sel_r, iss_sel_s;
    logic [OPRAND_WIDTH-1:0]     iss_opr1_r, iss_opr1_s, sel_opr1_s;
    logic [OPRAND_WIDTH-1:0]     iss_opr2_r, iss_opr2_s, sel_opr2_s;
    logic [OP_FUNC_WIDTH-1:0]    iss_op_r, iss_op_s, sel_op_s;
    logic [TAG_WIDTH-1:0]        iss_tag_r, iss_tag_s, sel_tag_s;

    function automatic src_t wake_src(input src_t src, input logic cdb_valid,
                                      input logic [TAG_WIDTH-1:0] cdb_tag,
                                      input logic [OPRAND_WIDTH-1:0] cdb_value);
        src_t res;
        res = src;
        if (!src.rdy && cdb_valid && (src.tag == cdb_tag)) begin
            res.rdy = 1'b1;
            res.val = cdb_value;
        end else begin
            res = src;
        end
        return res;
    endfunction

    assign disp_fire_s = disp_valid_i && disp_ready_r && !flush_i;
    assign iss_fire_s  = iss_valid_r && iss_ready_i && !flush_i;

    // Lowest-index free slot as a one-hot vector; zero when the station is full.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec_s[i] = entry_r[i].valid;
        end
        free_onehot_s = ~valid_vec_s & (valid_vec_s + {{(DEPTH-1){1'b0}}, 1'b1});
    end

    // Incoming entry; an operand broadcast on the CDB this cycle is captured directly.
    always_comb begin
        disp_entry_s.valid    = 1'b1;
        disp_entry_s.op_func  = disp_op_func_i;
        disp_entry_s.rob_tag  = disp_rob_tag_i;
        disp_entry_s.src1     = wake_src('{disp_src1_rdy_i, disp_src1_val_i, disp_src1_tag_i},
                                         cdb_valid_i, cdb_tag_i, cdb_value_i);
        disp_entry_s.src2     = wake_src('{disp_src2_rdy_i, disp_src2_val_i, disp_src2_tag_i},
                                         cdb_valid_i, cdb_tag_i, cdb_value_i);
    end

    // Next entry array: flush, free on issue, CDB wakeup, dispatch write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_s[i]      = entry_r[i];
            entry_s[i].src1 = wake_src(entry_r[i].src1, cdb_valid_i, cdb_tag_i, cdb_value_i);
            entry_s[i].src2 = wake_src(entry_r[i].src2, cdb_valid_i, cdb_tag_i, cdb_value_i);
            if (flush_i) begin
                entry_s[i].valid = 1'b0;
            end else if (iss_fire_s && iss_sel_r[i]) begin
                entry_s[i].valid = 1'b0;
            end else if (disp_fire_s && free_onehot_s[i]) begin
                entry_s[i] = disp_entry_s;
            end else begin
                entry_s[i].valid = entry_r[i].valid;
            end
        end
    end

    // A new entry is younger than every other slot; stale bits of free slots are masked by valid.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (disp_fire_s && free_onehot_s[i]) begin
                    age_s[i][j] = 1'b0;
                end else if (disp_fire_s && free_onehot_s[j]) begin
                    age_s[i][j] = 1'b1;
                end else begin
                    age_s[i][j] = age_r[i][j];
                end
            end
        end
    end

    // Selection runs on next-state entries so the issue port can be a plain register.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec_s[i] = entry_s[i].valid & entry_s[i].src1.rdy & entry_s[i].src2.rdy;
        end
    end

    rs_oldest_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .ready     (ready_vec_s),
        .age       (age_s),
        .grant     (grant_s),
        .any_ready (any_ready_s)
    );

    // AND-OR mux of the granted entry; all zero when nothing is granted.
    always_comb begin
        sel_opr1_s = '0;
        sel_opr2_s = '0;
        sel_op_s   = '0;
        sel_tag_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_opr1_s = sel_opr1_s | ({OPRAND_WIDTH{grant_s[i]}} & entry_s[i].src1.val);
            sel_opr2_s = sel_opr2_s | ({OPRAND_WIDTH{grant_s[i]}} & entry_s[i].src2.val);
            sel_op_s   = sel_op_s   | ({OP_FUNC_WIDTH{grant_s[i]}} & entry_s[i].op_func);
            sel_tag_s  = sel_tag_s  | ({TAG_WIDTH{grant_s[i]}} & entry_s[i].rob_tag);
        end
    end

    // Issue port: hold the locked entry until accepted, otherwise load the next winner.
    always_comb begin
        iss_valid_s = iss_valid_r;
        iss_sel_s   = iss_sel_r;
        iss_opr1_s  = iss_opr1_r;
        iss_opr2_s  = iss_opr2_r;
        iss_op_s    = iss_op_r;
        iss_tag_s   = iss_tag_r;
        if (flush_i) begin
            iss_valid_s = 1'b0;
            iss_sel_s   = '0;
            iss_opr1_s  = '0;
            iss_opr2_s  = '0;
            iss_op_s    = '0;
            iss_tag_s   = '0;
        end else if (iss_valid_r && !iss_ready_i) begin
            iss_valid_s = iss_valid_r;
        end else begin
            iss_valid_s = any_ready_s;
            iss_sel_s   = grant_s;
            iss_opr1_s  = sel_opr1_s;
            iss_opr2_s  = sel_opr2_s;
            iss_op_s    = sel_op_s;
            iss_tag_s   = sel_tag_s;
        end
    end

    // Occupancy and the registered dispatch-ready flag derived from it.
    always_comb begin
        if (flush_i) begin
            count_s = '0;
        end else begin
            count_s = count_r + CW'(disp_fire_s) - CW'(iss_fire_s);
        end
        disp_ready_s = (count_s != CW'(DEPTH));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
            age_r        <= '0;
            count_r      <= '0;
            disp_ready_r <= 1'b1;
            iss_valid_r  <= 1'b0;
            iss_sel_r    <= '0;
            iss_opr1_r   <= '0;
            iss_opr2_r   <= '0;
            iss_op_r     <= '0;
            iss_tag_r    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= entry_s[i];
            end
            age_r        <= age_s;
            count_r      <= count_s;
            disp_ready_r <= disp_ready_s;
            iss_valid_r  <= iss_valid_s;
            iss_sel_r    <= iss_sel_s;
            iss_opr1_r   <= iss_opr1_s;
            iss_opr2_r   <= iss_opr2_s;
            iss_op_r     <= iss_op_s;
            iss_tag_r    <= iss_tag_s;
        end
    end

    assign disp_ready_o  = disp_ready_r;
    assign count_o       = count_r;
    assign iss_valid_o   = iss_valid_r;
    assign iss_oprand1_o = iss_opr1_r;
    assign iss_oprand2_o = iss_opr2_r;
    assign iss_op_func_o = iss_op_r;
    assign iss_rob_tag_o = iss_tag_r;

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: an age-ordered instruction list models the station,
// a negedge monitor compares the issue port, occupancy and ready flag.
module tb_alu_rs;
    import rs_pkg::*;

    localparam int W  = 32;
    localparam int OW = 17;
    localparam int TW = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst, flush, disp_valid, disp_ready;
    logic [OW-1:0] disp_op;
    logic [TW-1:0] disp_tag, s1t, s2t, cdb_t, otag;
    logic          s1r, s2r, cdb_v, iss_valid, iss_ready;
    logic [W-1:0]  s1v, s2v, cdb_val, o1, o2;
    logic [OW-1:0] oop;
    logic [2:0]    count;

    typedef struct {
        int            id;
        logic [OW-1:0] op;
        logic [TW-1:0] tag;
        logic          r1, r2;
        logic [W-1:0]  v1, v2;
        logic [TW-1:0] t1, t2;
    } ins_t;

    typedef struct {
        logic [W-1:0]  o1, o2;
        logic [OW-1:0] op;
        logic [TW-1:0] tag;
    } exp_t;

    ins_t rs_q[$];
    exp_t exp_q[$];
    bit   pres = 1'b0;
    int   pres_id = 0;
    int   next_id = 0;
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_rs #(.OPRAND_WIDTH(W), .OP_FUNC_WIDTH(OW), .TAG_WIDTH(TW), .DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .disp_valid_i(disp_valid), .disp_ready_o(disp_ready),
        .disp_op_func_i(disp_op), .disp_rob_tag_i(disp_tag),
        .disp_src1_rdy_i(s1r), .disp_src2_rdy_i(s2r),
        .disp_src1_val_i(s1v), .disp_src2_val_i(s2v),
        .disp_src1_tag_i(s1t), .disp_src2_tag_i(s2t),
        .cdb_valid_i(cdb_v), .cdb_tag_i(cdb_t), .cdb_value_i(cdb_val),
        .iss_valid_o(iss_valid), .iss_ready_i(iss_ready),
        .iss_oprand1_o(o1), .iss_oprand2_o(o2),
        .iss_op_func_o(oop), .iss_rob_tag_o(otag), .count_o(count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list in dispatch order, oldest ready entry is presented and held.
    always @(posedge clk) begin : model_p
        int   hit;
        int   cnt_before;
        ins_t n;
        if (rst || flush) begin
            rs_q.delete();
            exp_q.delete();
            pres = 1'b0;
        end else begin
            cnt_before = rs_q.size();
            if (pres && iss_ready) begin
                hit = -1;
                foreach (rs_q[i]) if (rs_q[i].id == pres_id) hit = i;
                if (hit >= 0) rs_q.delete(hit);
                pres = 1'b0;
            end
            foreach (rs_q[i]) begin
                if (cdb_v && !rs_q[i].r1 && rs_q[i].t1 == cdb_t) begin
                    rs_q[i].r1 = 1'b1;
                    rs_q[i].v1 = cdb_val;
                end
                if (cdb_v && !rs_q[i].r2 && rs_q[i].t2 == cdb_t) begin
                    rs_q[i].r2 = 1'b1;
                    rs_q[i].v2 = cdb_val;
                end
            end
            if (disp_valid && cnt_before < D) begin
                n.id  = next_id;
                next_id++;
                n.op  = disp_op;
                n.tag = disp_tag;
                n.t1  = s1t;
                n.t2  = s2t;
                n.r1  = s1r || (cdb_v && s1t == cdb_t);
                n.r2  = s2r || (cdb_v && s2t == cdb_t);
                n.v1  = s1r ? s1v : cdb_val;
                n.v2  = s2r ? s2v : cdb_val;
                rs_q.push_back(n);
            end
            if (!pres) begin
                foreach (rs_q[i]) begin
                    if (!pres && rs_q[i].r1 && rs_q[i].r2) begin
                        pres    = 1'b1;
                        pres_id = rs_q[i].id;
                        exp_q.push_back('{rs_q[i].v1, rs_q[i].v2, rs_q[i].op, rs_q[i].tag});
                    end
                end
            end
        end
    end

    // Monitor: compares outputs mid-cycle, pops the scoreboard on each accepted issue.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("iss_valid", 64'(iss_valid), 64'(pres));
            chk("count", 64'(count), 64'(rs_q.size()));
            chk("disp_ready", 64'(disp_ready), 64'(rs_q.size() < D));
            if (iss_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_empty: issue tag %0h with nothing expected at %0t", otag, $time);
                end else begin
                    chk("iss_oprand1", 64'(o1), 64'(exp_q[0].o1));
                    chk("iss_oprand2", 64'(o2), 64'(exp_q[0].o2));
                    chk("iss_op_func", 64'(oop), 64'(exp_q[0].op));
                    chk("iss_rob_tag", 64'(otag), 64'(exp_q[0].tag));
                    if (iss_ready && !flush && !rst) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_oprands", {o1, o2}, 64'd0);
                chk("idle_op_tag", 64'({oop, otag}), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_v      = 1'b0;
        flush      = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic set_disp(input logic [OW-1:0] op, input logic [TW-1:0] tag,
                            input logic r1, input logic [W-1:0] v1, input logic [TW-1:0] t1,
                            input logic r2, input logic [W-1:0] v2, input logic [TW-1:0] t2);
        disp_valid = 1'b1;
        disp_op    = op;
        disp_tag   = tag;
        s1r = r1; s1v = v1; s1t = t1;
        s2r = r2; s2v = v2; s2t = t2;
    endtask

    logic [OW-1:0] ops [8];

    initial begin
        ops = '{ADD, SUB, ADDI, BEQ, JAL, AND, SRA, LUI};
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_tag = '0;
        s1r = 1'b0; s2r = 1'b0; s1v = '0; s2v = '0; s1t = '0; s2t = '0;
        cdb_v = 1'b0; cdb_t = '0; cdb_val = '0; iss_ready = 1'b0;
        step();
        step();
        idle();
        mon_en = 1'b1;
        chk("reset_ready", 64'(disp_ready), 64'd1);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_valid", 64'(iss_valid), 64'd0);

        // ADD 5 + 7, tag 3: issued the next cycle, station empty a cycle later.
        iss_ready = 1'b1;
        set_disp(ADD, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        step();
        idle();
        chk("add_valid", 64'(iss_valid), 64'd1);
        chk("add_opr1", 64'(o1), 64'd5);
        chk("add_opr2", 64'(o2), 64'd7);
        chk("add_tag", 64'(otag), 64'd3);
        step();
        chk("add_count", 64'(count), 64'd0);

        // SUB with src1 pending on tag 9, CDB delivers 100 two cycles later.
        set_disp(SUB, 4'd2, 1'b0, 32'd0, 4'd9, 1'b1, 32'd20, 4'd0);
        step();
        idle();
        step();
        chk("sub_wait", 64'(iss_valid), 64'd0);
        cdb_v = 1'b1; cdb_t = 4'd9; cdb_val = 32'd100;
        step();
        idle();
        chk("sub_valid", 64'(iss_valid), 64'd1);
        chk("sub_opr1", 64'(o1), 64'd100);
        step();

        // Fill all entries, a fifth dispatch is ignored, then drain oldest first.
        iss_ready = 1'b0;
        for (int k = 1; k <= D; k++) begin
            set_disp(ADDI, TW'(k), 1'b1, 32'(k), 4'd0, 1'b1, 32'(k * 10), 4'd0);
            step();
        end
        idle();
        chk("full_ready", 64'(disp_ready), 64'd0);
        set_disp(XOR, 4'd5, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        step();
        idle();
        chk("full_count", 64'(count), 64'(D));
        chk("full_head", 64'(otag), 64'd1);
        iss_ready = 1'b1;
        step();
        chk("drain_second", 64'(otag), 64'd2);
        for (int k = 0; k < D; k++) step();
        chk("drain_count", 64'(count), 64'd0);

        // Young entry locked; the older one wakes later and must wait its turn.
        iss_ready = 1'b0;
        set_disp(OR, 4'd10, 1'b0, 32'd0, 4'd5, 1'b1, 32'd1, 4'd0);
        step();
        set_disp(AND, 4'd11, 1'b1, 32'd2, 4'd0, 1'b1, 32'd3, 4'd0);
        step();
        idle();
        cdb_v = 1'b1; cdb_t = 4'd5; cdb_val = 32'd55;
        step();
        idle();
        step();
        chk("lock_hold", 64'(otag), 64'd11);
        iss_ready = 1'b1;
        step();
        chk("lock_next_tag", 64'(otag), 64'd10);
        chk("lock_next_opr1", 64'(o1), 64'd55);
        step();

        // Dispatch whose src2 tag matches the same-cycle CDB broadcast.
        set_disp(SLT, 4'd6, 1'b1, 32'd8, 4'd0, 1'b0, 32'd0, 4'd7);
        cdb_v = 1'b1; cdb_t = 4'd7; cdb_val = 32'hABCD;
        step();
        idle();
        chk("bypass_valid", 64'(iss_valid), 64'd1);
        chk("bypass_opr2", 64'(o2), 64'hABCD);
        step();

        // Flush with three entries, a same-cycle dispatch and a handshake.
        iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_disp(BEQ, TW'(k + 12), 1'b1, 32'(k), 4'd0, 1'b1, 32'(k), 4'd0);
            step();
        end
        idle();
        chk("pre_flush_count", 64'(count), 64'd3);
        flush = 1'b1;
        iss_ready = 1'b1;
        set_disp(SUB, 4'd15, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        step();
        idle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(iss_valid), 64'd0);
        chk("flush_ready", 64'(disp_ready), 64'd1);

        // Randomised traffic including occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            flush      = ($urandom_range(0, 59) == 0);
            disp_valid = ($urandom_range(0, 9) < 6);
            disp_op    = ops[$urandom_range(0, 7)];
            disp_tag   = TW'($urandom_range(0, 15));
            s1r        = ($urandom_range(0, 1) == 1);
            s2r        = ($urandom_range(0, 1) == 1);
            s1v        = $urandom;
            s2v        = $urandom;
            s1t        = TW'($urandom_range(0, 15));
            s2t        = TW'($urandom_range(0, 15));
            cdb_v      = ($urandom_range(0, 9) < 4);
            cdb_t      = TW'($urandom_range(0, 15));
            cdb_val    = $urandom;
            iss_ready  = ($urandom_range(0, 9) < 7);
            step();
        end
        idle();
        step();
        step();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
